// File: rtl/adder_accum_nbit.sv
// adder_accum_nbit: valid/ready operand accumulator with IDLE/ACC/HOLD FSM; ADDER_ACCUM_SAT_EN enables saturation
module adder_accum_nbit #(
    parameter int N         = 10,
    parameter int ACC_W     = 12,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [7:0] cnt, cnt_nx, cnt_inc;
    logic ovf, ovf_nx, fire;
    logic [ACC_W:0] sum;
    always_comb begin
        in_ready  = state != HOLD;
        out_valid = state == HOLD;
        fire      = in_valid && in_ready;
        sum       = {1'b0, acc} + {{(ACC_W+1-N){1'b0}}, in_data};
        cnt_inc   = cnt + 8'd1;
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        ovf_nx    = ovf;
        if (state == IDLE && fire) begin
            acc_nx   = {{(ACC_W-N){1'b0}}, in_data};
            cnt_nx   = 8'd1;
            ovf_nx   = 1'b0;
            state_nx = (in_last || MAX_BEATS == 1) ? HOLD : ACC;
        end else if (state == ACC && fire) begin
            cnt_nx = cnt_inc;
            ovf_nx = ovf | sum[ACC_W];
`ifdef ADDER_ACCUM_SAT_EN
            acc_nx = ovf_nx ? '1 : sum[ACC_W-1:0];
`else
            acc_nx = sum[ACC_W-1:0];
`endif
            state_nx = (in_last || cnt_inc == 8'(MAX_BEATS)) ? HOLD : ACC;
        end else if (state == HOLD && out_ready) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;
endmodule

// File: doc/adder_accum_nbit.md
ADDER_ACCUM_NBIT -- requirements
Module: adder_accum_nbit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter N SHALL be declared with default 10 and sets the operand width in bits.
REQ-003 Parameter ACC_W SHALL be declared with default 12 and sets the accumulator/result width (legal: ACC_W >= N+1).
REQ-004 Parameter MAX_BEATS SHALL be declared with default 4 and sets the operands per result before auto-termination (legal: 1..255).
REQ-005 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-006 Port rst_n SHALL be an input, 1 bit wide, and is the synchronous active-low reset.
REQ-007 Port in_valid SHALL be an input, 1 bit wide, and qualifies in_data and in_last.
REQ-008 Port in_ready SHALL be an output, 1 bit wide, and indicates that the block accepts an operand.
REQ-009 Port in_data SHALL be an input, N bits wide, and carries the unsigned operand.
REQ-010 Port in_last SHALL be an input, 1 bit wide, and marks the final operand of a group.
REQ-011 Port out_valid SHALL be an output, 1 bit wide, and indicates that a result is presented.
REQ-012 Port out_ready SHALL be an input, 1 bit wide, and indicates that the consumer accepts the result.
REQ-013 Port out_sum SHALL be an output, ACC_W bits wide, and carries the accumulated sum.
REQ-014 Port out_count SHALL be an output, 8 bits wide, and carries the number of operands summed.
REQ-015 Port out_ovf SHALL be an output, 1 bit wide, and flags that a carry out of ACC_W occurred in the group.

Function
REQ-016 An operand transfer SHALL occur on a rising clk edge when in_valid=1 and in_ready=1; no other condition SHALL alter the accumulator.
REQ-017 The FSM SHALL have three states: IDLE, ACC and HOLD; in_ready=1 in IDLE/ACC, 0 in HOLD; out_valid=1 only in HOLD.
REQ-018 IDLE, on transfer: acc=zero-extended in_data, cnt=1, ovf=0; next state HOLD if in_last=1 or MAX_BEATS=1, else ACC.
REQ-019 ACC, on transfer: acc=acc+in_data (N-bit operand zero-extended to ACC_W), cnt=cnt+1, ovf|=carry out of bit ACC_W-1.
REQ-020 ACC SHALL go to HOLD on the transfer where in_last=1 or cnt reaches MAX_BEATS, whichever comes first; otherwise it stays in ACC.
REQ-021 With no transfer, the state and accumulator SHALL hold; idle gaps in in_valid are allowed mid-group.
REQ-022 Latency: out_valid SHALL rise the cycle after the terminating transfer, with out_sum/out_count/out_ovf valid on that same cycle.
REQ-023 HOLD: outputs SHALL remain stable while out_ready=0; on out_valid&&out_ready, the next state SHALL be IDLE and out_valid SHALL drop the following cycle.
REQ-024 in_last presented in IDLE SHALL produce a one-operand result.
REQ-025 Accumulation SHALL wrap modulo 2^ACC_W unless saturation is compiled in (REQ-029).
REQ-026 out_count SHALL equal the number of operands transferred in the group (1..MAX_BEATS).

Reset
REQ-027 With rst_n=0 at a clk edge: state=IDLE, acc=0, cnt=0, ovf=0; out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=1 from the first cycle after reset release.
REQ-028 Reset mid-group or in HOLD SHALL discard the partial or pending result with no output transfer; the next group starts fresh.

Configuration
REQ-029 Macro ADDER_ACCUM_SAT_EN: when defined, a carry out SHALL clamp acc to 2^ACC_W-1, set ovf, and hold the clamp for the rest of the group; when undefined, acc SHALL wrap and ovf SHALL still be set.

Verification
REQ-030 N=10, ACC_W=12, MAX_BEATS=4; beats 100, 200, 300 (last on 300) -> next cycle out_valid=1, out_sum=600, out_count=3, out_ovf=0.
REQ-031 Four beats of 1023, in_last=0 -> auto-terminate; out_sum=4092, out_count=4, out_ovf=0; in_ready=0 in HOLD.
REQ-032 ACC_W=11; beats 1023, 1023, 2 (last) -> without macro: out_sum=0, out_ovf=1; with ADDER_ACCUM_SAT_EN: out_sum=2047, out_ovf=1.
REQ-033 Hold out_ready=0 for 5 cycles after a result -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE, out_valid=0 the next cycle.
REQ-034 Two beats 5, 7, then rst_n=0 for 1 cycle, then beat 9 with last -> out_sum=9, out_count=1, and no earlier out_valid.
REQ-035 One beat 42 with in_last=1 in IDLE, in_valid gaps inside a 3-beat group -> out_sum=42, out_count=1; the gapped group sums correctly.
